am_error_monitor: RTL and testbench

// - Downstream consumer of an unsigned 8x8 approximate multiplier: takes operand pairs plus the

---
 rtl/am_pkg.sv | 42 ++++
 rtl/am_err_dist.sv | 20 ++
 rtl/am_error_monitor.sv | 140 ++++++++++++++
 tb/tb_am_error_monitor.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/am_pkg.sv
// Shared types, default widths and saturating-arithmetic helpers for the
// approximate-multiplier error monitor.
package am_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } am_state_e;

  localparam int unsigned AM_W     = 8;
  localparam int unsigned AM_CNT_W = 16;
  localparam int unsigned AM_ACC_W = 40;

  // Unsigned add clamped to 2^w-1; operands must already fit in w bits (w <= 62).
  function automatic logic [63:0] sat_add_u(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int unsigned w);
    logic [63:0] lim;
    logic [63:0] s;
    lim = (64'd1 << w) - 64'd1;
    s   = a + b;
    return (s > lim) ? lim : s;
  endfunction

  // Signed add clamped to the w-bit two's-complement range (w <= 62).
  function automatic logic signed [63:0] sat_add_s(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] s;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    s  = a + b;
    if (s > hi)      return hi;
    else if (s < lo) return lo;
    else             return s;
  endfunction

endpackage

// File: rtl/am_err_dist.sv
// Combinational error distance between an approximate and an exact product:
// two's-complement difference, its magnitude, and a nonzero flag.
module am_err_dist #(
  parameter int unsigned W = 8
) (
  input  logic [2*W-1:0] exact_i,
  input  logic [2*W-1:0] z_apx_i,
  output logic [2*W:0]   d_o,
  output logic [2*W-1:0] dabs_o,
  output logic           nz_o
);

  logic [2*W:0] neg;

  assign d_o    = {1'b0, z_apx_i} - {1'b0, exact_i};
  assign neg    = -d_o;
  assign dabs_o = d_o[2*W] ? neg[2*W-1:0] : d_o[2*W-1:0];
  assign nz_o   = |d_o;

endmodule

// File: rtl/am_error_monitor.sv
// Error-statistics monitor for an 8x8 approximate multiplier: accepts a window
// of operand/product pairs, recomputes exact products and accumulates error stats.
module am_error_monitor
  import am_pkg::*;
#(
  parameter int unsigned W     = AM_W,
  parameter int unsigned CNT_W = AM_CNT_W,
  parameter int unsigned ACC_W = AM_ACC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     x,
  input  logic [W-1:0]     y,
  input  logic [2*W-1:0]   z_apx,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] sum_ed,
  output logic [ACC_W:0]   sum_sed,
  output logic [2*W-1:0]   max_ed,
  output logic [CNT_W-1:0] err_cnt
);

  am_state_e        state_q;
  logic [CNT_W-1:0] nsamp_q, cnt_q;
  logic             xfer, start_ok;

  logic             v1_q, v2_q;
  logic [2*W-1:0]   exact1_q, z1_q;
  logic [2*W:0]     d2_q, d_s1;
  logic [2*W-1:0]   abs2_q, abs_s1;
  logic             nz2_q, nz_s1;

  logic [ACC_W-1:0] sum_ed_q, sum_ed_d;
  logic [ACC_W:0]   sum_sed_q, sum_sed_d;
  logic [2*W-1:0]   max_ed_q, max_ed_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  assign in_ready = (state_q == RUN) && (cnt_q < nsamp_q);
  assign xfer     = in_valid && in_ready;
  assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));
  assign busy     = (state_q == RUN) || (state_q == DRAIN);
  assign done     = (state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      nsamp_q <= '0;
      cnt_q   <= '0;
    end else if (start_ok) begin
      nsamp_q <= num_samples;
      cnt_q   <= '0;
      state_q <= (num_samples != '0) ? RUN : DONE;
    end else begin
      case (state_q)
        RUN: if (xfer) begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == nsamp_q - CNT_W'(1)) state_q <= DRAIN;
        end
        // S2 retires on the same edge, so stats are final when done rises.
        DRAIN:   if (!v1_q) state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: ;
      endcase
    end
  end

  am_err_dist #(.W(W)) u_dist (
    .exact_i (exact1_q),
    .z_apx_i (z1_q),
    .d_o     (d_s1),
    .dabs_o  (abs_s1),
    .nz_o    (nz_s1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      exact1_q <= '0;
      z1_q     <= '0;
      d2_q     <= '0;
      abs2_q   <= '0;
      nz2_q    <= 1'b0;
    end else begin
      v1_q <= xfer;
      v2_q <= v1_q;
      if (xfer) begin
        exact1_q <= (2*W)'(x) * (2*W)'(y);
        z1_q     <= z_apx;
      end
      if (v1_q) begin
        d2_q   <= d_s1;
        abs2_q <= abs_s1;
        nz2_q  <= nz_s1;
      end
    end
  end

  always_comb begin
    sum_ed_d  = sum_ed_q;
    sum_sed_d = sum_sed_q;
    max_ed_d  = max_ed_q;
    err_cnt_d = err_cnt_q;
    if (start_ok) begin
      sum_ed_d  = '0;
      sum_sed_d = '0;
      max_ed_d  = '0;
      err_cnt_d = '0;
    end else if (v2_q) begin
      sum_ed_d  = ACC_W'(sat_add_u(64'(sum_ed_q), 64'(abs2_q), ACC_W));
      sum_sed_d = (ACC_W+1)'(sat_add_s(64'($signed(sum_sed_q)), 64'($signed(d2_q)), ACC_W + 1));
      if (abs2_q > max_ed_q) max_ed_d = abs2_q;
      if (nz2_q && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_ed_q  <= '0;
      sum_sed_q <= '0;
      max_ed_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      sum_ed_q  <= sum_ed_d;
      sum_sed_q <= sum_sed_d;
      max_ed_q  <= max_ed_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign sum_ed  = sum_ed_q;
  assign sum_sed = sum_sed_q;
  assign max_ed  = max_ed_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_am_error_monitor.sv
// Directed bench for am_error_monitor: default instance plus an ACC_W=17
// instance for accumulator saturation.
module tb_am_error_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] num_samples = '0;
  logic [7:0]  x = '0, y = '0;
  logic [15:0] z = '0;

  logic        in_ready_a, busy_a, done_a;
  logic [39:0] sum_ed_a;
  logic [40:0] sum_sed_a;
  logic [15:0] max_ed_a, err_cnt_a;

  logic        in_ready_b, busy_b, done_b;
  logic [16:0] sum_ed_b;
  logic [17:0] sum_sed_b;
  logic [15:0] max_ed_b, err_cnt_b;

  int n_chk = 0, n_pass = 0;
  int xfer_a = 0, xfer_b = 0, done_a_n = 0;

  am_error_monitor u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready_a), .x(x), .y(y), .z_apx(z),
    .busy(busy_a), .done(done_a), .sum_ed(sum_ed_a), .sum_sed(sum_sed_a),
    .max_ed(max_ed_a), .err_cnt(err_cnt_a)
  );

  am_error_monitor #(.ACC_W(17)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready_b), .x(x), .y(y), .z_apx(z),
    .busy(busy_b), .done(done_b), .sum_ed(sum_ed_b), .sum_sed(sum_sed_b),
    .max_ed(max_ed_b), .err_cnt(err_cnt_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (in_valid && in_ready_a) xfer_a++;
    if (in_valid && in_ready_b) xfer_b++;
    if (done_a) done_a_n++;
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_win(input bit sel, input int n);
    num_samples = 16'(n);
    if (sel) start_b = 1'b1;
    else     start_a = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic send(input bit sel, input int a, input int b, input int zz);
    logic rdy;
    x = 8'(a); y = 8'(b); z = 16'(zz);
    in_valid = 1'b1;
    rdy = sel ? in_ready_b : in_ready_a;
    for (int i = 0; i < 20 && !rdy; i++) begin
      tick();
      rdy = sel ? in_ready_b : in_ready_a;
    end
    if (!rdy) check("ready_timeout", longint'(rdy), 1);
    else tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input bit sel, output int cyc);
    cyc = 0;
    while (!(sel ? done_b : done_a) && cyc < 30) begin
      tick();
      cyc++;
    end
  endtask

  task automatic check_stats_a(input string tag, input longint ed, input longint sed,
                               input longint mx, input longint ec);
    check({tag, "_sum_ed"},  longint'(sum_ed_a), ed);
    check({tag, "_sum_sed"}, longint'($signed(sum_sed_a)), sed);
    check({tag, "_max_ed"},  longint'(max_ed_a), mx);
    check({tag, "_err_cnt"}, longint'(err_cnt_a), ec);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    int c, x0, d0;

    // Reset state
    tick(); tick();
    check("rst_in_ready", longint'(in_ready_a), 0);
    check("rst_busy", longint'(busy_a), 0);
    check("rst_done", longint'(done_a), 0);
    check_stats_a("rst", 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();

    // Exact products, back-to-back transfers
    start_win(0, 3);
    check("t1_busy", longint'(busy_a), 1);
    send(0, 3, 5, 15);
    send(0, 255, 255, 65025);
    send(0, 10, 10, 100);
    wait_done(0, c);
    check("t1_latency", longint'(c), 2);
    check("t1_busy_done", longint'(busy_a), 0);
    check_stats_a("t1", 0, 0, 0, 0);
    tick();
    check("t1_pulse", longint'(done_a), 0);

    // Mixed-sign errors
    start_win(0, 2);
    send(0, 16, 16, 250);
    send(0, 4, 4, 20);
    wait_done(0, c);
    check("t2_latency", longint'(c), 2);
    check_stats_a("t2", 10, -2, 6, 2);
    tick(); tick(); tick();
    check("t2_hold_sum_ed", longint'(sum_ed_a), 10);

    // Empty window
    start_win(0, 0);
    check("t3_done", longint'(done_a), 1);
    check("t3_busy", longint'(busy_a), 0);
    check_stats_a("t3", 0, 0, 0, 0);
    tick();
    check("t3_pulse", longint'(done_a), 0);
    check("t3_busy_after", longint'(busy_a), 0);

    // Gapped in_valid, extra valid after the window fills
    x0 = xfer_a;
    d0 = done_a_n;
    start_win(0, 4);
    send(0, 1, 2, 3);    tick();
    send(0, 5, 5, 20);   tick();
    send(0, 200, 3, 600); tick();
    send(0, 7, 9, 70);
    check("t4_ready_drop", longint'(in_ready_a), 0);
    x = 8'd1; y = 8'd1; z = 16'd9;
    in_valid = 1'b1;
    wait_done(0, c);
    in_valid = 1'b0;
    check("t4_latency", longint'(c), 2);
    tick();
    check("t4_xfers", longint'(xfer_a - x0), 4);
    check("t4_done_pulses", longint'(done_a_n - d0), 1);
    check_stats_a("t4", 13, 3, 7, 3);

    // Asynchronous reset mid-window
    start_win(0, 5);
    send(0, 3, 5, 20);
    send(0, 2, 2, 1);
    tick(); tick();
    check("t5_pre_sum_ed", longint'(sum_ed_a), 8);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_busy", longint'(busy_a), 0);
    check("t5_rst_ready", longint'(in_ready_a), 0);
    check_stats_a("t5_rst", 0, 0, 0, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    start_win(0, 1);
    send(0, 3, 3, 10);
    wait_done(0, c);
    check("t5_latency", longint'(c), 2);
    check_stats_a("t5_new", 1, 1, 1, 1);

    // Narrow accumulator saturation; start ignored while busy
    x0 = xfer_b;
    start_win(1, 4);
    send(1, 0, 0, 65535);
    send(1, 0, 0, 65535);
    num_samples = 16'd1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("t6_busy", longint'(busy_b), 1);
    send(1, 0, 0, 65535);
    send(1, 0, 0, 65535);
    wait_done(1, c);
    check("t6_latency", longint'(c), 2);
    check("t6_xfers", longint'(xfer_b - x0), 4);
    check("t6_sum_ed", longint'(sum_ed_b), 131071);
    check("t6_sum_sed", longint'($signed(sum_sed_b)), 131071);
    check("t6_max_ed", longint'(max_ed_b), 65535);
    check("t6_err_cnt", longint'(err_cnt_b), 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
